// File: rtl/write_back_stage_if.sv
// Execute-to-write-back handshake plus the load read bus.
//   ex_*  : one execute result per ex_valid & ex_ready transfer
//   bus_* : single outstanding read; bus_req/bus_addr held until bus_ack
// slave  : the write-back stage
// master : the surrounding execute unit and memory bus
interface write_back_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_y1_channel;
  logic [31:0] ex_y1_data;
  logic [1:0]  ex_y2_channel;
  logic [31:0] ex_y2_data;
  logic        ex_mem_rd;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output ex_valid, ex_y1_channel, ex_y1_data, ex_y2_channel, ex_y2_data, ex_mem_rd,
    input  ex_ready,
    input  bus_req, bus_addr,
    output bus_ack, bus_rdata
  );

  modport slave (
    input  ex_valid, ex_y1_channel, ex_y1_data, ex_y2_channel, ex_y2_data, ex_mem_rd,
    output ex_ready,
    output bus_req, bus_addr,
    input  bus_ack, bus_rdata
  );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage between execute and the register file.
// Accepts one execute result per handshake, performs the bus read for loads
// (aborted after ACK_TIMEOUT wait cycles), and pulses the per-register write
// strobes for exactly one cycle; the register file commits on that edge and
// the bypass network forwards the same back_* values in that cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wb_if           execute handshake and load read bus (slave side)
//   back_<reg>      registered write-back data, holds when its strobe is low
//   back_<reg>_c    one-cycle write enable for back_<reg>
//   pc_load         one-cycle PC redirect strobe, pc_target holds the target
//   bus_err         one-cycle pulse when a load times out
//   busy            stage is not IDLE
module write_back_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  write_back_stage_if.slave wb_if,
  output logic [31:0]       back_r1,
  output logic [31:0]       back_r2,
  output logic [31:0]       back_r3,
  output logic [31:0]       back_r4,
  output logic [31:0]       back_r5,
  output logic [31:0]       back_r6,
  output logic [31:0]       back_cs,
  output logic [31:0]       back_ds,
  output logic [31:0]       back_flag,
  output logic [31:0]       back_tpc,
  output logic [31:0]       back_ipc,
  output logic [31:0]       back_sp,
  output logic [31:0]       back_tlb,
  output logic              back_r1_c,
  output logic              back_r2_c,
  output logic              back_r3_c,
  output logic              back_r4_c,
  output logic              back_r5_c,
  output logic              back_r6_c,
  output logic              back_cs_c,
  output logic              back_ds_c,
  output logic              back_flag_c,
  output logic              back_tpc_c,
  output logic              back_ipc_c,
  output logic              back_sp_c,
  output logic              back_tlb_c,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic              bus_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  // Slot numbering of the write-back register file (output order r1..tlb).
  localparam logic [3:0]  SLOT_FLAG   = 4'd8;
  localparam logic [3:0]  SLOT_SP     = 4'd11;
  localparam logic [3:0]  SLOT_TLB    = 4'd12;
  localparam logic [3:0]  CH_PC       = 4'd14;
  localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

  // {hit, slot} for a y1 channel; channels 1..11 map straight onto slots
  // 0..10, while tlb and sp are swapped relative to the output order.
  function automatic logic [4:0] y1_slot(input logic [3:0] ch);
    logic [4:0] s;
    s = '0;
    case (ch)
      4'd0, 4'd14, 4'd15: s = '0;
      4'd12:              s = {1'b1, SLOT_TLB};
      4'd13:              s = {1'b1, SLOT_SP};
      default:            s = {1'b1, ch - 4'd1};
    endcase
    return s;
  endfunction

  function automatic logic [4:0] y2_slot(input logic [1:0] ch);
    logic [4:0] s;
    s = '0;
    case (ch)
      2'd1:    s = {1'b1, SLOT_FLAG};
      2'd2:    s = {1'b1, SLOT_SP};
      default: s = '0;
    endcase
    return s;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [12:0][31:0] back_q, back_d;
  logic [12:0]       back_c_q, back_c_d;
  logic              pc_load_q, pc_load_d;
  logic [31:0]       pc_target_q, pc_target_d;
  logic              bus_err_q, bus_err_d;

  logic [3:0]        y1_chan_p1;
  logic [1:0]        y2_chan_p1;
  logic [31:0]       y2_data_p1;

  logic              ex_ready_w;
  logic              accept;
  logic              commit;
  logic [3:0]        cm_y1_chan;
  logic [31:0]       cm_y1_data;
  logic [1:0]        cm_y2_chan;
  logic [31:0]       cm_y2_data;
  logic [4:0]        y1_hit, y2_hit;

  assign ex_ready_w = (state_q == IDLE) && !rst;
  assign accept     = wb_if.ex_valid && ex_ready_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    back_d      = back_q;
    back_c_d    = '0;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    bus_err_d   = 1'b0;
    commit      = 1'b0;
    cm_y1_chan  = wb_if.ex_y1_channel;
    cm_y1_data  = wb_if.ex_y1_data;
    cm_y2_chan  = wb_if.ex_y2_channel;
    cm_y2_data  = wb_if.ex_y2_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb_if.ex_mem_rd) begin
            state_d    = WAIT_ACK;
            bus_req_d  = 1'b1;
            bus_addr_d = wb_if.ex_y1_data;
            cnt_d      = 16'd1;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        // Ack wins over a timeout falling on the same cycle.
        if (wb_if.bus_ack) begin
          state_d    = COMMIT;
          bus_req_d  = 1'b0;
          cnt_d      = '0;
          commit     = 1'b1;
          cm_y1_chan = y1_chan_p1;
          cm_y1_data = wb_if.bus_rdata;
          cm_y2_chan = y2_chan_p1;
          cm_y2_data = y2_data_p1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // Strobes for the load are on the outputs this cycle; hold off new
      // work for one cycle so the load result is the only commit.
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // y2 is applied after y1 so it wins when both name the same register.
    y1_hit = y1_slot(cm_y1_chan);
    y2_hit = y2_slot(cm_y2_chan);
    if (commit) begin
      if (y1_hit[4]) begin
        back_d[y1_hit[3:0]]   = cm_y1_data;
        back_c_d[y1_hit[3:0]] = 1'b1;
      end
      if (cm_y1_chan == CH_PC) begin
        pc_load_d   = 1'b1;
        pc_target_d = cm_y1_data;
      end
      if (y2_hit[4]) begin
        back_d[y2_hit[3:0]]   = cm_y2_data;
        back_c_d[y2_hit[3:0]] = 1'b1;
      end
    end
  end

  // ---- stage register: control, strobes and write-back data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      back_q      <= '0;
      back_c_q    <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      back_q      <= back_d;
      back_c_q    <= back_c_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // ---- load context held across the bus wait (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept && wb_if.ex_mem_rd) begin
      y1_chan_p1 <= wb_if.ex_y1_channel;
      y2_chan_p1 <= wb_if.ex_y2_channel;
      y2_data_p1 <= wb_if.ex_y2_data;
    end
  end

  assign wb_if.ex_ready = ex_ready_w;
  assign wb_if.bus_req  = bus_req_q;
  assign wb_if.bus_addr = bus_addr_q;

  assign back_r1   = back_q[0];
  assign back_r2   = back_q[1];
  assign back_r3   = back_q[2];
  assign back_r4   = back_q[3];
  assign back_r5   = back_q[4];
  assign back_r6   = back_q[5];
  assign back_cs   = back_q[6];
  assign back_ds   = back_q[7];
  assign back_flag = back_q[8];
  assign back_tpc  = back_q[9];
  assign back_ipc  = back_q[10];
  assign back_sp   = back_q[11];
  assign back_tlb  = back_q[12];

  assign back_r1_c   = back_c_q[0];
  assign back_r2_c   = back_c_q[1];
  assign back_r3_c   = back_c_q[2];
  assign back_r4_c   = back_c_q[3];
  assign back_r5_c   = back_c_q[4];
  assign back_r6_c   = back_c_q[5];
  assign back_cs_c   = back_c_q[6];
  assign back_ds_c   = back_c_q[7];
  assign back_flag_c = back_c_q[8];
  assign back_tpc_c  = back_c_q[9];
  assign back_ipc_c  = back_c_q[10];
  assign back_sp_c   = back_c_q[11];
  assign back_tlb_c  = back_c_q[12];

  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign bus_err   = bus_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  write_back_stage_if bus_if();

  logic [31:0] back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_cs;
  logic [31:0] back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb;
  logic back_r1_c, back_r2_c, back_r3_c, back_r4_c, back_r5_c, back_r6_c, back_cs_c;
  logic back_ds_c, back_flag_c, back_tpc_c, back_ipc_c, back_sp_c, back_tlb_c;
  logic        pc_load, bus_err, busy;
  logic [31:0] pc_target;

  write_back_stage #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wb_if(bus_if),
    .back_r1(back_r1), .back_r2(back_r2), .back_r3(back_r3), .back_r4(back_r4),
    .back_r5(back_r5), .back_r6(back_r6), .back_cs(back_cs), .back_ds(back_ds),
    .back_flag(back_flag), .back_tpc(back_tpc), .back_ipc(back_ipc), .back_sp(back_sp),
    .back_tlb(back_tlb),
    .back_r1_c(back_r1_c), .back_r2_c(back_r2_c), .back_r3_c(back_r3_c), .back_r4_c(back_r4_c),
    .back_r5_c(back_r5_c), .back_r6_c(back_r6_c), .back_cs_c(back_cs_c), .back_ds_c(back_ds_c),
    .back_flag_c(back_flag_c), .back_tpc_c(back_tpc_c), .back_ipc_c(back_ipc_c),
    .back_sp_c(back_sp_c), .back_tlb_c(back_tlb_c),
    .pc_load(pc_load), .pc_target(pc_target), .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register order r1..r6, cs, ds, flag, tpc, ipc, sp, tlb (index 0..12).
  logic [12:0][31:0] dut_back;
  logic [12:0]       dut_c;
  assign dut_back = {back_tlb, back_sp, back_ipc, back_tpc, back_flag, back_ds, back_cs,
                     back_r6, back_r5, back_r4, back_r3, back_r2, back_r1};
  assign dut_c    = {back_tlb_c, back_sp_c, back_ipc_c, back_tpc_c, back_flag_c, back_ds_c,
                     back_cs_c, back_r6_c, back_r5_c, back_r4_c, back_r3_c, back_r2_c, back_r1_c};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the architectural register values and this cycle's pulses.
  logic [12:0][31:0] exp_back;
  logic [12:0]       exp_c;
  logic              exp_pc_load;
  logic [31:0]       exp_pc_target;
  // y1 channel -> register index, -1 for no register write.
  int y1_map [16] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 11, -1, -1};
  int y2_map [4]  = '{-1, 8, 11, -1};

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_idle();
    exp_c       = '0;
    exp_pc_load = 1'b0;
  endtask

  task automatic model_reset();
    exp_back      = '0;
    exp_pc_target = '0;
    model_idle();
  endtask

  task automatic model_commit(input logic [3:0] y1ch, input logic [31:0] y1d,
                              input logic [1:0] y2ch, input logic [31:0] y2d);
    model_idle();
    if (y1_map[y1ch] >= 0) begin
      exp_back[y1_map[y1ch]] = y1d;
      exp_c[y1_map[y1ch]]    = 1'b1;
    end
    if (y1ch == 4'd14) begin
      exp_pc_load   = 1'b1;
      exp_pc_target = y1d;
    end
    if (y2_map[y2ch] >= 0) begin
      exp_back[y2_map[y2ch]] = y2d;
      exp_c[y2_map[y2ch]]    = 1'b1;
    end
  endtask

  task automatic drive_alu(input logic v, input logic [3:0] y1ch, input logic [31:0] y1d,
                           input logic [1:0] y2ch, input logic [31:0] y2d);
    bus_if.ex_valid      = v;
    bus_if.ex_mem_rd     = 1'b0;
    bus_if.ex_y1_channel = y1ch;
    bus_if.ex_y1_data    = y1d;
    bus_if.ex_y2_channel = y2ch;
    bus_if.ex_y2_data    = y2d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_alu(1'b1, 4'd3, 32'hFFFF_0000, 2'd2, 32'h1234);
    bus_if.bus_ack = 1'b1;
    repeat (3) cycle();
    model_reset();
    n_checks++; if (bus_if.ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", bus_if.ex_ready); end
    n_checks++; if (dut_c !== 13'd0 || dut_back !== exp_back) begin n_err++; $display("FAIL reset_back strobes %b data %h exp zero", dut_c, dut_back); end
    n_checks++; if (pc_load !== 1'b0 || pc_target !== 32'd0 || bus_err !== 1'b0) begin n_err++; $display("FAIL reset_pc pc_load %b pc_target %h bus_err %b exp 0", pc_load, pc_target, bus_err); end
    n_checks++; if (bus_if.bus_req !== 1'b0 || bus_if.bus_addr !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_bus req %b addr %h busy %b exp 0", bus_if.bus_req, bus_if.bus_addr, busy); end
    rst = 1'b0;
    bus_if.ex_valid = 1'b0;
    bus_if.bus_ack  = 1'b0;
    #1;
    n_checks++; if (bus_if.ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b exp 1", bus_if.ex_ready); end
  endtask

  task automatic test_alu_single();
    drive_alu(1'b1, 4'd3, 32'h1234_5678, 2'd0, 32'h0);
    cycle();
    bus_if.ex_valid = 1'b0;
    model_commit(4'd3, 32'h1234_5678, 2'd0, 32'h0);
    n_checks++; if (dut_c !== 13'b0_0000_0000_0100 || back_r3 !== 32'h1234_5678) begin n_err++; $display("FAIL alu_r3 strobes %b r3 %h exp %b %h", dut_c, back_r3, 13'b100, 32'h1234_5678); end
    n_checks++; if (dut_back !== exp_back) begin n_err++; $display("FAIL alu_back got %h exp %h", dut_back, exp_back); end
    cycle();
    model_idle();
    n_checks++; if (dut_c !== exp_c || back_r3 !== 32'h1234_5678) begin n_err++; $display("FAIL alu_r3_drop strobes %b r3 %h exp 0 held", dut_c, back_r3); end
  endtask

  task automatic test_back_to_back();
    drive_alu(1'b1, 4'd1, 32'hA, 2'd0, 32'h0);
    cycle();
    model_commit(4'd1, 32'hA, 2'd0, 32'h0);
    n_checks++; if (dut_c !== exp_c || back_r1 !== 32'hA) begin n_err++; $display("FAIL b2b_first strobes %b r1 %h exp %b a", dut_c, back_r1, exp_c); end
    n_checks++; if (bus_if.ex_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b exp 1", bus_if.ex_ready); end
    drive_alu(1'b1, 4'd1, 32'hB, 2'd0, 32'h0);
    cycle();
    bus_if.ex_valid = 1'b0;
    model_commit(4'd1, 32'hB, 2'd0, 32'h0);
    n_checks++; if (dut_c !== exp_c || back_r1 !== 32'hB) begin n_err++; $display("FAIL b2b_second strobes %b r1 %h exp %b b", dut_c, back_r1, exp_c); end
    cycle();
    model_idle();
    n_checks++; if (dut_c !== 13'd0) begin n_err++; $display("FAIL b2b_end strobes %b exp 0", dut_c); end
  endtask

  task automatic test_flag_collision();
    drive_alu(1'b1, 4'd9, 32'h1, 2'd1, 32'h80);
    cycle();
    bus_if.ex_valid = 1'b0;
    model_commit(4'd9, 32'h1, 2'd1, 32'h80);
    n_checks++; if (dut_c !== 13'h100 || back_flag !== 32'h80) begin n_err++; $display("FAIL flag_collision strobes %b flag %h exp %b 80", dut_c, back_flag, 13'h100); end
    n_checks++; if (dut_back !== exp_back) begin n_err++; $display("FAIL flag_back got %h exp %h", dut_back, exp_back); end
    cycle();
    model_idle();
  endtask

  task automatic test_alu_stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic        v;
      logic [3:0]  c1;
      logic [1:0]  c2;
      logic [31:0] d1, d2;
      v  = ($urandom_range(0, 3) != 0);
      c1 = 4'($urandom_range(0, 15));
      c2 = 2'($urandom_range(0, 2));
      d1 = $urandom;
      d2 = $urandom;
      n_checks++; if (bus_if.ex_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready got %b exp 1", bus_if.ex_ready); end
      drive_alu(v, c1, d1, c2, d2);
      cycle();
      if (v) model_commit(c1, d1, c2, d2);
      else   model_idle();
      n_checks++; if (dut_c !== exp_c) begin n_err++; $display("FAIL stream_strobes i=%0d got %b exp %b", i, dut_c, exp_c); end
      n_checks++; if (dut_back !== exp_back) begin n_err++; $display("FAIL stream_back i=%0d got %h exp %h", i, dut_back, exp_back); end
      n_checks++; if (pc_load !== exp_pc_load || pc_target !== exp_pc_target) begin n_err++; $display("FAIL stream_pc i=%0d got %b %h exp %b %h", i, pc_load, pc_target, exp_pc_load, exp_pc_target); end
      n_checks++; if (bus_if.bus_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stream_idle i=%0d bus_req %b busy %b exp 0", i, bus_if.bus_req, busy); end
    end
    bus_if.ex_valid = 1'b0;
    cycle();
    model_idle();
  endtask

  // ack_at: bus_req cycle (1-based) on which bus_ack is driven, 0 for never.
  task automatic do_load(input string name, input logic [3:0] y1ch, input logic [31:0] addr,
                         input logic [1:0] y2ch, input logic [31:0] y2d,
                         input logic [31:0] rdata, input int ack_at);
    n_checks++; if (bus_if.ex_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_before got %b exp 1", name, bus_if.ex_ready); end
    drive_alu(1'b1, y1ch, addr, y2ch, y2d);
    bus_if.ex_mem_rd = 1'b1;
    cycle();
    model_idle();
    for (int k = 1; k <= TMO; k++) begin
      n_checks++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== addr) begin n_err++; $display("FAIL %s bus k=%0d req %b addr %h exp 1 %h", name, k, bus_if.bus_req, bus_if.bus_addr, addr); end
      n_checks++; if (bus_if.ex_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s wait k=%0d ready %b busy %b exp 0 1", name, k, bus_if.ex_ready, busy); end
      n_checks++; if (dut_c !== 13'd0 || bus_err !== 1'b0 || pc_load !== 1'b0) begin n_err++; $display("FAIL %s wait_quiet k=%0d strobes %b err %b pc %b exp 0", name, k, dut_c, bus_err, pc_load); end
      // Unrelated traffic offered while busy must not be taken.
      drive_alu(1'b1, 4'($urandom_range(1, 13)), $urandom, 2'($urandom_range(0, 2)), $urandom);
      bus_if.ex_mem_rd = 1'($urandom_range(0, 1));
      bus_if.bus_ack   = (k == ack_at);
      bus_if.bus_rdata = (k == ack_at) ? rdata : $urandom;
      cycle();
      bus_if.ex_valid = 1'b0;
      bus_if.bus_ack  = 1'b0;
      if (k == ack_at) begin
        model_commit(y1ch, rdata, y2ch, y2d);
        n_checks++; if (dut_c !== exp_c) begin n_err++; $display("FAIL %s commit_strobes got %b exp %b", name, dut_c, exp_c); end
        n_checks++; if (dut_back !== exp_back) begin n_err++; $display("FAIL %s commit_back got %h exp %h", name, dut_back, exp_back); end
        n_checks++; if (pc_load !== exp_pc_load || pc_target !== exp_pc_target) begin n_err++; $display("FAIL %s commit_pc got %b %h exp %b %h", name, pc_load, pc_target, exp_pc_load, exp_pc_target); end
        n_checks++; if (bus_if.bus_req !== 1'b0 || bus_if.ex_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s commit_ctrl req %b ready %b busy %b exp 0 0 1", name, bus_if.bus_req, bus_if.ex_ready, busy); end
        cycle();
        model_idle();
        n_checks++; if (dut_c !== 13'd0 || pc_load !== 1'b0) begin n_err++; $display("FAIL %s post_strobes %b pc %b exp 0", name, dut_c, pc_load); end
        n_checks++; if (bus_if.ex_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s post_ready %b busy %b exp 1 0", name, bus_if.ex_ready, busy); end
        return;
      end
    end
    n_checks++; if (bus_if.bus_req !== 1'b0 || bus_err !== 1'b1) begin n_err++; $display("FAIL %s timeout req %b err %b exp 0 1", name, bus_if.bus_req, bus_err); end
    n_checks++; if (dut_c !== 13'd0 || pc_load !== 1'b0 || dut_back !== exp_back) begin n_err++; $display("FAIL %s timeout_nowrite strobes %b pc %b back %h", name, dut_c, pc_load, dut_back); end
    n_checks++; if (bus_if.ex_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s timeout_ready %b busy %b exp 1 0", name, bus_if.ex_ready, busy); end
    cycle();
    n_checks++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL %s err_pulse got %b exp 0", name, bus_err); end
  endtask

  task automatic test_load_random(input int n);
    for (int i = 0; i < n; i++) begin
      do_load("load_rand", 4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 2)),
              $urandom, $urandom, int'($urandom_range(0, TMO)));
    end
  endtask

  task automatic test_ack_idle();
    for (int i = 0; i < 2; i++) begin
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = $urandom;
      cycle();
      model_idle();
      n_checks++; if (dut_c !== 13'd0 || busy !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL ack_idle strobes %b busy %b req %b exp 0", dut_c, busy, bus_if.bus_req); end
    end
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_reset_wait();
    drive_alu(1'b1, 4'd5, 32'h0000_4000, 2'd2, 32'h77);
    bus_if.ex_mem_rd = 1'b1;
    cycle();
    bus_if.ex_valid  = 1'b0;
    bus_if.ex_mem_rd = 1'b0;
    n_checks++; if (bus_if.bus_req !== 1'b1) begin n_err++; $display("FAIL rstwait_req_before got %b exp 1", bus_if.bus_req); end
    rst = 1'b1;
    cycle();
    model_reset();
    n_checks++; if (bus_if.bus_req !== 1'b0 || bus_if.bus_addr !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rstwait_bus req %b addr %h busy %b exp 0", bus_if.bus_req, bus_if.bus_addr, busy); end
    n_checks++; if (dut_c !== 13'd0 || dut_back !== exp_back || pc_target !== 32'd0) begin n_err++; $display("FAIL rstwait_back strobes %b back %h pc %h exp 0", dut_c, dut_back, pc_target); end
    rst = 1'b0;
    cycle();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_F00D;
    cycle();
    bus_if.bus_ack = 1'b0;
    n_checks++; if (dut_c !== 13'd0 || busy !== 1'b0 || bus_if.ex_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_late_ack strobes %b busy %b ready %b", dut_c, busy, bus_if.ex_ready); end
    cycle();
    n_checks++; if (dut_c !== 13'd0 || dut_back !== exp_back) begin n_err++; $display("FAIL rstwait_after strobes %b back %h", dut_c, dut_back); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.ex_valid      = 1'b0;
    bus_if.ex_mem_rd     = 1'b0;
    bus_if.ex_y1_channel = '0;
    bus_if.ex_y1_data    = '0;
    bus_if.ex_y2_channel = '0;
    bus_if.ex_y2_data    = '0;
    bus_if.bus_ack       = 1'b0;
    bus_if.bus_rdata     = '0;
    model_reset();

    test_reset();
    test_alu_single();
    test_back_to_back();
    test_flag_collision();
    test_alu_stream(60);
    do_load("load_sp", 4'd13, 32'h100, 2'd2, 32'h1FC, 32'hDEAD_BEEF, 3);
    do_load("timeout", 4'd2, 32'h200, 2'd1, 32'h55, 32'h0, 0);
    do_load("ack_on_timeout", 4'd4, 32'h300, 2'd0, 32'h0, 32'h0BAD_F00D, TMO);
    do_load("load_pc", 4'd14, 32'h400, 2'd1, 32'h3, 32'h8000_0040, 1);
    do_load("load_discard", 4'd15, 32'h500, 2'd2, 32'h2468, 32'h1357_9BDF, 2);
    test_load_random(12);
    test_ack_idle();
    test_reset_wait();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Pipeline stage directly after execute and directly before the register file.
- Takes one execute result per handshake. Performs the memory read for load instructions, with a timeout.
- Drives the per-register back_<reg> / back_<reg>_c write strobes for exactly one cycle. The register file commits on that cycle's clock edge, and the bypass network forwards the same values combinationally in that cycle.
- Also drives PC redirects and bus error reporting.

Parameters:
ACK_TIMEOUT, 255, bus wait cycles (counted from first bus_req cycle) before a load is aborted; legal range 1..65535.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
ex_valid  input  1  execute result valid
ex_ready  output  1  stage can accept; transfer when ex_valid & ex_ready at clock edge
ex_y1_channel  input  4  y1 destination: 0 none, 1-6 r1-r6, 7 cs, 8 ds, 9 flag, 10 tpc, 11 ipc, 12 tlb, 13 sp, 14 pc, 15 ignored
ex_y1_data  input  32  y1 result; for loads, the read address
ex_y2_channel  input  2  0 none, 1 flag, 2 sp
ex_y2_data  input  32  y2 result
ex_mem_rd  input  1  y1 destination receives bus read data addressed by ex_y1_data
bus_req  output  1  read request, held until ack or timeout
bus_addr  output  32  read address, stable while bus_req
bus_ack  input  1  read data valid this cycle
bus_rdata  input  32  read data
back_r1..back_r6, back_cs, back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb  output  32 each  write-back data
back_r1_c..back_tlb_c (13 strobes, same order)  output  1 each  write enable for matching back_* register
pc_load  output  1  one-cycle PC redirect strobe
pc_target  output  32  redirect target
bus_err  output  1  one-cycle pulse on load timeout
busy  output  1  high in any non-IDLE state

Behaviour:
- Reset:
  - state IDLE; wait counter 0.
  - All back_* = 0 and all *_c = 0.
  - pc_load = 0, pc_target = 0, bus_req = 0, bus_addr = 0, bus_err = 0.
- States: IDLE, WAIT_ACK, COMMIT.
- ex_ready = (state == IDLE) & ~rst.
- Strobes: all *_c, pc_load and bus_err are registered and default to 0 every cycle unless set below. back_* data is registered and holds its last value when its strobe is low.
- IDLE, non-load accept at edge N:
  - In cycle N+1, set the y1 target strobe and data.
  - ex_y2_channel 1 sets back_flag; 2 sets back_sp.
  - y1 channel 14 drives pc_load = 1 and pc_target = ex_y1_data; no register strobe.
  - Channels 0 and 15 write nothing.
  - Stay IDLE, so back-to-back accepts give one commit per cycle.
- IDLE, load accept:
  - Latch channels, y2 data and address; go to WAIT_ACK.
  - bus_req = 1 and bus_addr = ex_y1_data from the next cycle.
  - Counter starts at 1 on the first bus_req cycle.
- WAIT_ACK:
  - bus_ack sampled high at edge M: drop bus_req, capture bus_rdata, go to COMMIT. Strobes pulse in cycle M+1 with y1 data = captured bus_rdata; y2 is committed alongside. COMMIT returns to IDLE at edge M+1, so ex_ready is high again in cycle M+2.
  - Otherwise increment the counter. When counter == ACK_TIMEOUT and no ack, drop bus_req, pulse bus_err for one cycle, commit nothing (y2 also discarded), return to IDLE.
  - Ack arriving on the timeout cycle takes priority over the timeout.
- y1 and y2 to the same register (y1 channel 9 with y2 = 1, or y1 channel 13 with y2 = 2): y2 data wins, single strobe.
- Load with y1 channel 14: redirect to loaded data via pc_load; no register strobe.
- Load with y1 channel 0/15: bus read still performed; data discarded; y2 still committed.
- bus_ack while IDLE or COMMIT is ignored.
- rst mid-operation (any state): next cycle follows the reset rules above; bus_req drops; a pending commit is lost; a later ack is ignored.
- busy = (state != IDLE).

Test Plan:
- Reset then ALU result: accept y1 = 3, data 0x1234_5678 at edge N -> cycle N+1 back_r3 = 0x12345678, back_r3_c = 1, all other strobes 0; cycle N+2 back_r3_c = 0.
- Back-to-back: accept y1 = 1 with 0xA, then y1 = 1 with 0xB on consecutive edges -> back_r1_c high two consecutive cycles with 0xA then 0xB; ex_ready never drops.
- Load: mem_rd, y1 = 13 address 0x100, y2 = 2 data 0x1FC; ack after 3 cycles with 0xDEAD_BEEF -> bus_req high 3 cycles, bus_addr 0x100. Commit cycle: back_sp_c = 1 with back_sp = 0x1FC (y2 wins over loaded data); ex_ready low until the cycle after commit.
- Timeout with ACK_TIMEOUT = 4 and no ack -> bus_req high exactly 4 cycles, bus_err pulses 1 cycle, no strobe, ex_ready returns high.
- Flag collision: y1 = 9 data 0x1, y2 = 1 data 0x80 -> single back_flag_c pulse, back_flag = 0x80.
- Reset in WAIT_ACK, then ack 2 cycles later -> bus_req 0 the cycle after rst, no strobes, state IDLE, ack ignored.
